// File: rtl/data_mem_resp_if.sv
// Data-port bus between the single-cycle core and its memory responder.
// Handshake: there is no valid/ready pair. Every cycle carries one access.
// MemWrite qualifies a store that commits at the closing rising edge.
// ReadData is always valid and combinational for the current Mem_WrAddr.
interface data_mem_resp_if;
  logic        MemWrite;
  logic [1:0]  StoreSrc;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output StoreSrc,
    output Mem_WrAddr,
    output Mem_WrData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  StoreSrc,
    input  Mem_WrAddr,
    input  Mem_WrData,
    output ReadData
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data memory responder: byte-strobed word RAM plus an MMIO window holding
// a cycle timer with compare interrupt, a sticky misalign flag and GPIO output.
module data_mem_resp #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_resp_if.slave        bus,
  output logic                  timer_irq,
  output logic [31:0]           gpio_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;

  localparam logic [1:0] REG_MTIME    = 2'd0;
  localparam logic [1:0] REG_MTIMECMP = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_GPIO     = 2'd3;

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] mtime;
  logic [31:0] mtimecmp;
  logic [1:0]  status;
  logic [31:0] gpio_reg;

  logic          is_mmio;
  logic          mmio_hit;
  logic [1:0]    mmio_reg;
  logic [1:0]    byte_off;
  logic [AW-1:0] ram_idx;

  assign is_mmio  = (bus.Mem_WrAddr[31:16] == MMIO_BASE[31:16]);
  assign mmio_hit = is_mmio && (bus.Mem_WrAddr[15:4] == 12'h000);
  assign mmio_reg = bus.Mem_WrAddr[3:2];
  assign byte_off = bus.Mem_WrAddr[1:0];
  assign ram_idx  = bus.Mem_WrAddr[AW+1:2];

  // Store decode: misalignment, RAM lane strobes and lane-replicated data
  logic        misaligned;
  logic        store_ok;
  logic [3:0]  ram_strb;
  logic [31:0] lane_data;

  always_comb begin
    misaligned = 1'b0;
    ram_strb   = 4'b0000;
    lane_data  = bus.Mem_WrData;
    case (bus.StoreSrc)
      ST_WORD: begin
        misaligned = (byte_off != 2'b00);
        ram_strb   = 4'b1111;
        lane_data  = bus.Mem_WrData;
      end
      ST_HALF: begin
        misaligned = byte_off[0];
        ram_strb   = byte_off[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{bus.Mem_WrData[15:0]}};
      end
      ST_BYTE: begin
        ram_strb   = 4'b0001 << byte_off;
        lane_data  = {4{bus.Mem_WrData[7:0]}};
      end
      default: begin
        ram_strb   = 4'b0000;
      end
    endcase
    store_ok = bus.MemWrite && !misaligned;
    if (!store_ok || is_mmio) begin
      ram_strb = 4'b0000;
    end
  end

  // RAM has no reset; stores are blocked while reset is held
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < 4; l++) begin
        if (ram_strb[l]) begin
          ram[ram_idx][8*l +: 8] <= lane_data[8*l +: 8];
        end
      end
    end
  end

  // MMIO accepts aligned word stores only; sub-word stores are dropped silently
  logic mmio_we;
  logic wr_cmp;
  logic wr_status;
  logic wr_gpio;
  logic set_misalign;
  logic timer_match;
  logic [1:0] status_clr;
  logic [1:0] status_next;

  always_comb begin
    mmio_we      = store_ok && mmio_hit && (bus.StoreSrc == ST_WORD);
    wr_cmp       = mmio_we && (mmio_reg == REG_MTIMECMP);
    wr_status    = mmio_we && (mmio_reg == REG_STATUS);
    wr_gpio      = mmio_we && (mmio_reg == REG_GPIO);
    set_misalign = bus.MemWrite && misaligned;
    timer_match  = (mtime == mtimecmp);
    status_clr   = wr_status ? bus.Mem_WrData[1:0] : 2'b00;
    // A set in the same cycle as a write-1-to-clear wins
    status_next  = (status & ~status_clr) | {set_misalign, timer_match};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime    <= 32'h0000_0000;
      mtimecmp <= 32'hFFFF_FFFF;
      status   <= 2'b00;
      gpio_reg <= 32'h0000_0000;
    end else begin
      mtime  <= mtime + 32'd1;
      status <= status_next;
      if (wr_cmp) begin
        mtimecmp <= bus.Mem_WrData;
      end
      if (wr_gpio) begin
        gpio_reg <= bus.Mem_WrData;
      end
    end
  end

  // Load path: select RAM or MMIO word, then align the addressed byte to bit 0
  logic [31:0] mmio_word;
  logic [31:0] rd_word;

  always_comb begin
    mmio_word = 32'h0000_0000;
    if (mmio_hit) begin
      case (mmio_reg)
        REG_MTIME:    mmio_word = mtime;
        REG_MTIMECMP: mmio_word = mtimecmp;
        REG_STATUS:   mmio_word = {30'h0, status};
        REG_GPIO:     mmio_word = gpio_reg;
        default:      mmio_word = 32'h0000_0000;
      endcase
    end
    rd_word = is_mmio ? mmio_word : ram[ram_idx];
  end

  assign bus.ReadData = rd_word >> {byte_off, 3'b000};
  assign timer_irq    = status[0];
  assign gpio_out     = gpio_reg;

endmodule
